// File: rtl/ht_pkg.sv
// rtl/ht_pkg.sv - shared entry type, stage constants and width helper for hazard_tracker
package ht_pkg;

  localparam int DST_MAX_W = 16;
  localparam int RDY_MAX_W = 8;

  localparam int ST_E = 1;
  localparam int ST_M = 2;
  localparam int ST_W = 3;

  // Fields are sized for the widest supported configuration; instances zero-extend into them.
  typedef struct packed {
    logic                 v;
    logic [DST_MAX_W-1:0] dst;
    logic [RDY_MAX_W-1:0] rdy;
  } ht_entry_t;

  function automatic int fsel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/ht_stage.sv
// rtl/ht_stage.sv - one tracked pipeline entry with per-source destination compare
module ht_stage
  import ht_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NSRC  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  ht_entry_t             entry_d,
  input  logic [NSRC*REG_W-1:0] src,
  input  logic [NSRC-1:0]       src_on,
  output ht_entry_t             entry_q,
  output logic [NSRC-1:0]       match
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      entry_q <= '0;
    end else if (load) begin
      entry_q <= entry_d;
    end
  end

  // Register 0 is hardwired and never produces a hazard.
  always_comb begin
    match = '0;
    for (int i = 0; i < NSRC; i++) begin
      match[i] = src_on[i] && (src[i*REG_W +: REG_W] != '0) && entry_q.v &&
                 (entry_q.dst == DST_MAX_W'(src[i*REG_W +: REG_W]));
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - decode-stage forwarding select and stall generation; HT_STALL_CNT_EN adds a stall counter
module hazard_tracker
  import ht_pkg::*;
#(
  parameter  int REG_W  = 5,
  parameter  int STAGES = 3,
  parameter  int NSRC   = 2,
  localparam int FSEL_W = fsel_w(STAGES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_v,
  input  logic                   issue_wr,
  input  logic [REG_W-1:0]       issue_dst,
  input  logic [FSEL_W-1:0]      issue_rdy,
  input  logic [NSRC*REG_W-1:0]  src,
  input  logic [NSRC-1:0]        src_on,
  input  logic                   hold,
  input  logic                   flush_d,
  input  logic                   flush_all,
`ifdef HT_STALL_CNT_EN
  input  logic                   stall_cnt_clr,
  output logic [31:0]            stall_cnt,
`endif
  output logic [NSRC*FSEL_W-1:0] fwd_sel,
  output logic                   stall_d,
  output logic                   issue_ack,
  output logic [STAGES-1:0]      pipe_valid,
  output logic                   wb_v,
  output logic [REG_W-1:0]       wb_dst
);

  ht_entry_t              ent   [1:STAGES];
  logic [NSRC-1:0]        match [1:STAGES];
  ht_entry_t              issue_ent;
  logic [RDY_MAX_W-1:0]   rdy_c;
  logic [NSRC-1:0]        found;
  logic [NSRC-1:0]        src_stall;
  logic                   unused_wb_hi;

  always_comb begin
    rdy_c = RDY_MAX_W'(issue_rdy);
    if (rdy_c == '0) begin
      rdy_c = RDY_MAX_W'(ST_E);
    end else if (rdy_c > RDY_MAX_W'(STAGES)) begin
      rdy_c = RDY_MAX_W'(STAGES);
    end
  end

  assign issue_ent = '{v: issue_ack & issue_wr, dst: DST_MAX_W'(issue_dst), rdy: rdy_c};

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    ht_entry_t load_ent;
    if (s == 1) begin : g_first
      assign load_ent = issue_ent;
    end else begin : g_rest
      assign load_ent = ent[s-1];
    end

    ht_stage #(.REG_W(REG_W), .NSRC(NSRC)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush_all),
      .load    (~hold),
      .entry_d (load_ent),
      .src     (src),
      .src_on  (src_on),
      .entry_q (ent[s]),
      .match   (match[s])
    );

    assign pipe_valid[s-1] = ent[s].v;
  end

  // Youngest match decides; an unready youngest blocks forwarding from older copies.
  always_comb begin
    fwd_sel   = '0;
    src_stall = '0;
    found     = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int s = 1; s <= STAGES; s++) begin
        if (!found[i] && match[s][i]) begin
          found[i] = 1'b1;
          if (RDY_MAX_W'(s) >= ent[s].rdy) begin
            fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(s);
          end else begin
            src_stall[i] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_d      = issue_v & (|src_stall);
  assign issue_ack    = issue_v & ~stall_d & ~hold & ~flush_d & ~flush_all;
  assign wb_v         = ent[STAGES].v;
  assign wb_dst       = ent[STAGES].dst[REG_W-1:0];
  assign unused_wb_hi = ^(ent[STAGES].dst >> REG_W);

`ifdef HT_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_d && !hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed self-checking bench for hazard_tracker
module tb_hazard_tracker;

  localparam int REG_W  = 5;
  localparam int STAGES = 3;
  localparam int NSRC   = 2;
  localparam int FSEL_W = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   issue_v;
  logic                   issue_wr;
  logic [REG_W-1:0]       issue_dst;
  logic [FSEL_W-1:0]      issue_rdy;
  logic [NSRC*REG_W-1:0]  src;
  logic [NSRC-1:0]        src_on;
  logic                   hold;
  logic                   flush_d;
  logic                   flush_all;
  logic [NSRC*FSEL_W-1:0] fwd_sel;
  logic                   stall_d;
  logic                   issue_ack;
  logic [STAGES-1:0]      pipe_valid;
  logic                   wb_v;
  logic [REG_W-1:0]       wb_dst;
`ifdef HT_STALL_CNT_EN
  logic                   stall_cnt_clr;
  logic [31:0]            stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_tracker #(.REG_W(REG_W), .STAGES(STAGES), .NSRC(NSRC)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_v       (issue_v),
    .issue_wr      (issue_wr),
    .issue_dst     (issue_dst),
    .issue_rdy     (issue_rdy),
    .src           (src),
    .src_on        (src_on),
    .hold          (hold),
    .flush_d       (flush_d),
    .flush_all     (flush_all),
`ifdef HT_STALL_CNT_EN
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt),
`endif
    .fwd_sel       (fwd_sel),
    .stall_d       (stall_d),
    .issue_ack     (issue_ack),
    .pipe_valid    (pipe_valid),
    .wb_v          (wb_v),
    .wb_dst        (wb_dst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_v = 0; issue_wr = 0; issue_dst = '0; issue_rdy = '0;
    src = '0; src_on = '0; hold = 0; flush_d = 0; flush_all = 0;
`ifdef HT_STALL_CNT_EN
    stall_cnt_clr = 0;
`endif
  endtask

  task automatic drain();
    idle();
    flush_all = 1;
    tick();
    flush_all = 0;
  endtask

  task automatic set_issue(input logic [REG_W-1:0] d, input logic [FSEL_W-1:0] r, input logic wr);
    issue_v = 1; issue_wr = wr; issue_dst = d; issue_rdy = r;
  endtask

  task automatic set_src(input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1, input logic [NSRC-1:0] on);
    src = {s1, s0}; src_on = on;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
    checks++; if (pipe_valid !== 3'b000) begin errors++; $display("FAIL reset_pipe_valid got %b want 000", pipe_valid); end
    checks++; if (wb_v !== 1'b0) begin errors++; $display("FAIL reset_wb_v got %b want 0", wb_v); end
    checks++; if (wb_dst !== 5'd0) begin errors++; $display("FAIL reset_wb_dst got %0d want 0", wb_dst); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_d); end
    checks++; if (issue_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", issue_ack); end
    checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL reset_fwd_sel got %h want 0", fwd_sel); end
  endtask

  task automatic test_alu_chain();
    drain();
    set_issue(5'd8, 2'd1, 1'b1);
    #1;
    checks++; if (issue_ack !== 1'b1) begin errors++; $display("FAIL alu_issue_ack got %b want 1", issue_ack); end
    tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd8, 5'd0, 2'b01);
    #1;
    checks++; if (fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL alu_fwd_e got %0d want 1", fwd_sel[1:0]); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall_d); end
    tick();
    checks++; if (fwd_sel[1:0] !== 2'd2) begin errors++; $display("FAIL alu_fwd_m got %0d want 2", fwd_sel[1:0]); end
    checks++; if (pipe_valid !== 3'b010) begin errors++; $display("FAIL alu_pipe_valid got %b want 010", pipe_valid); end
  endtask

  task automatic test_load_use();
    drain();
    set_issue(5'd9, 2'd2, 1'b1);
    tick();
    set_issue(5'd10, 2'd1, 1'b1);
    set_src(5'd0, 5'd9, 2'b10);
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall_d); end
    checks++; if (issue_ack !== 1'b0) begin errors++; $display("FAIL lu_ack_stalled got %b want 0", issue_ack); end
    checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL lu_fwd_stalled got %h want 0", fwd_sel); end
    tick();
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %b want 0", stall_d); end
    checks++; if (fwd_sel[3:2] !== 2'd2) begin errors++; $display("FAIL lu_fwd_m got %0d want 2", fwd_sel[3:2]); end
    checks++; if (issue_ack !== 1'b1) begin errors++; $display("FAIL lu_ack got %b want 1", issue_ack); end
    tick();
    checks++; if (pipe_valid !== 3'b101) begin errors++; $display("FAIL lu_pipe_valid got %b want 101", pipe_valid); end
    checks++; if (wb_dst !== 5'd9) begin errors++; $display("FAIL lu_wb_dst got %0d want 9", wb_dst); end
  endtask

  task automatic test_youngest();
    drain();
    set_issue(5'd5, 2'd1, 1'b1); tick();
    idle(); tick();
    set_issue(5'd5, 2'd1, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd5, 5'd0, 2'b01);
    #1;
    checks++; if (pipe_valid !== 3'b101) begin errors++; $display("FAIL yw_pipe_valid got %b want 101", pipe_valid); end
    checks++; if (wb_v !== 1'b1 || wb_dst !== 5'd5) begin errors++; $display("FAIL yw_wb got v=%b dst=%0d want v=1 dst=5", wb_v, wb_dst); end
    checks++; if (fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL yw_fwd got %0d want 1", fwd_sel[1:0]); end
    drain();
    set_issue(5'd5, 2'd1, 1'b1); tick();
    idle(); tick();
    set_issue(5'd5, 2'd3, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd5, 5'd0, 2'b01);
    #1;
    checks++; if (stall_d !== 1'b1 || fwd_sel !== 4'd0) begin errors++; $display("FAIL yw_unready got stall=%b fwd=%h want stall=1 fwd=0", stall_d, fwd_sel); end
    drain();
    set_issue(5'd0, 2'd1, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd0, 5'd0, 2'b11);
    #1;
    checks++; if (pipe_valid !== 3'b001) begin errors++; $display("FAIL r0_pipe_valid got %b want 001", pipe_valid); end
    checks++; if (fwd_sel !== 4'd0 || stall_d !== 1'b0) begin errors++; $display("FAIL r0_nomatch got fwd=%h stall=%b want fwd=0 stall=0", fwd_sel, stall_d); end
  endtask

  task automatic test_rdy_edges();
    drain();
    set_issue(5'd12, 2'd0, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd12, 5'd0, 2'b01);
    #1;
    checks++; if (fwd_sel[1:0] !== 2'd1 || stall_d !== 1'b0) begin errors++; $display("FAIL rdy0_as_1 got fwd=%0d stall=%b want fwd=1 stall=0", fwd_sel[1:0], stall_d); end
    drain();
    set_issue(5'd13, 2'd3, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd13, 5'd0, 2'b01);
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL rdy3_stall_e got %b want 1", stall_d); end
    tick();
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL rdy3_stall_m got %b want 1", stall_d); end
    tick();
    checks++; if (stall_d !== 1'b0 || fwd_sel[1:0] !== 2'd3) begin errors++; $display("FAIL rdy3_fwd_w got stall=%b fwd=%0d want stall=0 fwd=3", stall_d, fwd_sel[1:0]); end
  endtask

  task automatic test_hold();
    drain();
    set_issue(5'd9, 2'd2, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd9, 5'd0, 2'b01);
    hold = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (pipe_valid !== 3'b001 || stall_d !== 1'b1 || issue_ack !== 1'b0) begin
        errors++; $display("FAIL hold_frozen[%0d] got pv=%b stall=%b ack=%b want pv=001 stall=1 ack=0", k, pipe_valid, stall_d, issue_ack);
      end
      tick();
    end
    hold = 0;
    #1;
    checks++; if (stall_d !== 1'b1 || issue_ack !== 1'b0) begin errors++; $display("FAIL hold_release got stall=%b ack=%b want stall=1 ack=0", stall_d, issue_ack); end
    tick();
    checks++; if (stall_d !== 1'b0 || fwd_sel[1:0] !== 2'd2 || issue_ack !== 1'b1) begin
      errors++; $display("FAIL hold_after got stall=%b fwd=%0d ack=%b want stall=0 fwd=2 ack=1", stall_d, fwd_sel[1:0], issue_ack);
    end
  endtask

  task automatic test_flush();
    drain();
    set_issue(5'd1, 2'd1, 1'b1); tick();
    set_issue(5'd2, 2'd1, 1'b1); tick();
    set_issue(5'd3, 2'd1, 1'b1); tick();
    checks++; if (pipe_valid !== 3'b111 || wb_dst !== 5'd1) begin errors++; $display("FAIL fl_full got pv=%b wb_dst=%0d want pv=111 wb_dst=1", pipe_valid, wb_dst); end
    flush_all = 1;
    hold = 1;
    #1;
    checks++; if (issue_ack !== 1'b0) begin errors++; $display("FAIL fl_all_ack got %b want 0", issue_ack); end
    tick();
    checks++; if (pipe_valid !== 3'b000 || wb_v !== 1'b0) begin errors++; $display("FAIL fl_all got pv=%b wb_v=%b want pv=000 wb_v=0", pipe_valid, wb_v); end
    flush_all = 0;
    hold = 0;
    set_issue(5'd4, 2'd1, 1'b1); tick();
    set_issue(5'd5, 2'd1, 1'b1); tick();
    checks++; if (pipe_valid !== 3'b011) begin errors++; $display("FAIL fl_d_before got %b want 011", pipe_valid); end
    set_issue(5'd6, 2'd1, 1'b1);
    flush_d = 1;
    #1;
    checks++; if (issue_ack !== 1'b0) begin errors++; $display("FAIL fl_d_ack got %b want 0", issue_ack); end
    tick();
    checks++; if (pipe_valid !== 3'b110 || wb_v !== 1'b1 || wb_dst !== 5'd4) begin
      errors++; $display("FAIL fl_d_after got pv=%b wb_v=%b wb_dst=%0d want pv=110 wb_v=1 wb_dst=4", pipe_valid, wb_v, wb_dst);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    set_issue(5'd7, 2'd2, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0);
    set_src(5'd7, 5'd0, 2'b01);
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL rm_pre_stall got %b want 1", stall_d); end
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++; if (pipe_valid !== 3'b000 || wb_v !== 1'b0 || wb_dst !== 5'd0) begin
      errors++; $display("FAIL rm_regs got pv=%b wb_v=%b wb_dst=%0d want 000 0 0", pipe_valid, wb_v, wb_dst);
    end
    checks++; if (stall_d !== 1'b0 || fwd_sel !== 4'd0) begin errors++; $display("FAIL rm_comb got stall=%b fwd=%h want 0 0", stall_d, fwd_sel); end
`ifdef HT_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d want 0", stall_cnt); end
`endif
  endtask

`ifdef HT_STALL_CNT_EN
  task automatic test_stall_cnt();
    drain();
    stall_cnt_clr = 1; tick(); stall_cnt_clr = 0;
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL sc_clear got %0d want 0", stall_cnt); end
    for (int k = 0; k < 3; k++) begin
      set_issue(5'd9, 2'd2, 1'b1); set_src(5'd0, 5'd0, 2'b00); tick();
      set_issue(5'd0, 2'd0, 1'b0); set_src(5'd0, 5'd9, 2'b10); tick();
      idle(); tick();
    end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL sc_three got %0d want 3", stall_cnt); end
    set_issue(5'd9, 2'd2, 1'b1); tick();
    set_issue(5'd0, 2'd0, 1'b0); set_src(5'd0, 5'd9, 2'b10);
    stall_cnt_clr = 1;
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL sc_clr_stall got %b want 1", stall_d); end
    tick();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL sc_clr_wins got %0d want 0", stall_cnt); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_rdy_edges();
    test_hold();
    test_flush();
    test_reset_mid();
`ifdef HT_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
Parametrised successor to the fixed E/M/W register-compare and forwarding logic in the core datapath. It tracks destination-register writes through a configurable number of post-decode stages (STAGES) and serves NSRC source operands in D. For each source it produces a forwarding select and a decode stall. Each in-flight write carries its own ready stage, so ALU, load and multicycle-style latencies are handled uniformly instead of being hard-coded.

Parameters:
REG_W, 5, register index width
STAGES, 3, tracked stages after D (1=E, 2=M, 3=W)
NSRC, 2, source operands checked in D
FSEL_W, $clog2(STAGES+1), forward-select width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_v  in  1  D holds a valid instruction
issue_wr  in  1  instruction writes a register
issue_dst  in  REG_W  destination register
issue_rdy  in  FSEL_W  first stage (1..STAGES) at which the result is forwardable
src  in  NSRC*REG_W  source register indices, packed, source 0 in LSBs
src_on  in  NSRC  source is actually read
hold  in  1  global freeze (memory not acked, MD busy)
flush_d  in  1  kill D instruction (branch redirect)
flush_all  in  1  kill all tracked entries (exception)
fwd_sel  out  NSRC*FSEL_W  per source: 0=register file, s=forward from stage s
stall_d  out  1  D must not advance
issue_ack  out  1  D instruction entered stage 1 this cycle
pipe_valid  out  STAGES  valid-and-writes flag per stage, bit s-1 = stage s
wb_v  out  1  stage STAGES entry valid and writing
wb_dst  out  REG_W  stage STAGES destination

Behaviour:
- Entry per stage: {v, dst, rdy}. v=0 means bubble. Entries with issue_wr=0 enter as v=0.
- Reset: all v=0, dst=0, rdy=0. stall_d=0, issue_ack=0, fwd_sel=0, pipe_valid=0, wb_v=0, wb_dst=0.
- Match rule: source i matches stage s iff src_on[i] & src[i]!=0 & v[s] & dst[s]==src[i]. Register 0 never matches.
- Priority: lowest s (youngest) wins. Older matches are ignored.
- Youngest match s is ready if s >= rdy[s]: fwd_sel[i]=s. Not ready: fwd_sel[i]=0 and the source raises a stall. No match: fwd_sel[i]=0.
- stall_d = issue_v & OR(source stalls). Combinational, zero latency. Also valid during hold.
- issue_ack = issue_v & ~stall_d & ~hold & ~flush_d & ~flush_all.
- Advance when ~hold:
  - stage s gets stage s-1 for s>1.
  - stage 1 gets {issue_ack & issue_wr, issue_dst, issue_rdy}; otherwise a bubble.
  - stage STAGES entry retires. The register file write is external.
- hold=1: all stages frozen, issue_ack=0.
- flush_all=1: all v=0 next cycle. Overrides hold and issue.
- flush_d alone: only stage 1 gets a bubble; older stages advance normally.
- issue_rdy=0 is treated as 1. issue_rdy>STAGES is clamped to STAGES.
- A stalled load-use clears without stimulus change once the producer advances to its rdy stage.
- All outputs other than stall_d, fwd_sel and issue_ack are registered.

Optional Feature:
Macro HT_STALL_CNT_EN.
- Defined: adds output stall_cnt, 32 bits, and input stall_cnt_clr.
  - Counts cycles with stall_d=1 & ~hold.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset or stall_cnt_clr; clear wins over an increment in the same cycle.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package ht_pkg:
  - ht_entry_t struct {v, dst, rdy}
  - stage index constants ST_E=1, ST_M=2, ST_W=3
  - function fsel_w(stages)
- Sub-module ht_stage, instantiated STAGES times. One entry register with load, hold and clear, plus the per-source match compare (v & dst==src & src!=0).
- Top level holds the priority select, stall OR-reduce, issue logic and the optional counter.

Test Plan:
- ALU chain: issue dst=8, rdy=1; next cycle src0=8 -> fwd_sel[0]=1, stall_d=0. One cycle later, another consumer -> fwd_sel[0]=2.
- Load-use: issue dst=9, rdy=2; next cycle src1=9 -> stall_d=1 for exactly 1 cycle, then fwd_sel[1]=2, issue_ack=1.
- Youngest wins: stage 3 dst=5, stage 1 dst=5 rdy=1; src0=5 -> fwd_sel[0]=1. Register 0: src=0 with stage 1 dst=0 -> fwd_sel=0, no stall.
- Hold: load in stage 1, hold=1 for 4 cycles -> pipe_valid frozen at 3'b001, stall_d=1 throughout, issue_ack=0. After release, stall clears 1 cycle later.
- Flush: stages full, flush_all together with hold -> pipe_valid=0 next cycle, wb_v=0. flush_d alone -> stage 1 bubble, pipe_valid 3'b011 -> 3'b110.
- HT_STALL_CNT_EN: 3 load-use stalls -> stall_cnt=3. stall_cnt_clr together with a stall -> 0. Reset mid-stream -> all outputs return to reset values in one cycle.
